core_run_monitor: RTL and testbench

//  Hardware launcher and completion checker for the multicore RISC-V array. It loads each core's

---
 rtl/core_run_monitor_pkg.sv | 25 ++
 rtl/core_run_monitor_tracker.sv | 113 +++++++++++
 rtl/core_run_monitor.sv | 139 +++++++++++++
 tb/tb_core_run_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_monitor_pkg.sv
// core_run_monitor_pkg: shared types and helpers for the core run monitor.
//   run_state_e   - top-level launcher FSM states
//   trk_state_e   - per-core tracker states
//   drain_cnt_width() - width of the per-core drain counter
package core_run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } run_state_e;

    typedef enum logic [1:0] {
        TRK_COUNT,
        TRK_DRAIN,
        TRK_FIN
    } trk_state_e;

    // The drain counter must be able to hold the value DRAIN_CYCLES.
    function automatic int unsigned drain_cnt_width(input int unsigned drain_cycles);
        return (drain_cycles < 2) ? 1 : $clog2(drain_cycles + 1);
    endfunction

endpackage

// File: rtl/core_run_monitor_tracker.sv
// core_run_tracker: completion tracker for one core.
//   clock, reset  - clock, synchronous active-high reset
//   clear         - start of a new run: drop all results
//   run           - top FSM is in RUN
//   timeout_hit   - global run limit reached this cycle
//   pc, end_pc    - live fetch PC and latched end PC
//   result        - live x9 of the core
//   done, pass, timed_out - registered verdict flags
//   cycles        - frozen run-time cycle count
module core_run_tracker
    import core_run_monitor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned CYCLE_BITS   = 32,
    parameter int unsigned DRAIN_CYCLES = 50
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    run,
    input  logic                    timeout_hit,
    input  logic [ADDRESS_BITS-1:0] pc,
    input  logic [ADDRESS_BITS-1:0] end_pc,
    input  logic [DATA_WIDTH-1:0]   result,
    output logic                    done,
    output logic                    pass,
    output logic                    timed_out,
    output logic [CYCLE_BITS-1:0]   cycles
);

    localparam int unsigned   DW         = drain_cnt_width(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);

    trk_state_e             state_q, state_d;
    logic [CYCLE_BITS-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0]          drain_q, drain_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   tmo_q, tmo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        done_d  = done_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        // Saturating increment; the cycle in which the end PC matches is counted.
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYCLE_BITS'(1);

        if (clear) begin
            state_d = TRK_COUNT;
            cnt_d   = '0;
            drain_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            tmo_d   = 1'b0;
        end else if (run) begin
            case (state_q)
                TRK_COUNT: begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d = TRK_FIN;
                        done_d  = 1'b1;
                        tmo_d   = 1'b1;
                    end else if (pc == end_pc) begin
                        state_d = TRK_DRAIN;
                        drain_d = '0;
                    end
                end
                TRK_DRAIN: begin
                    if (timeout_hit) begin
                        state_d = TRK_FIN;
                        done_d  = 1'b1;
                        tmo_d   = 1'b1;
                    end else if (drain_q == DRAIN_LAST) begin
                        state_d = TRK_FIN;
                        done_d  = 1'b1;
                        pass_d  = (result == '0);
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TRK_COUNT;
            cnt_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign timed_out = tmo_q;
    assign cycles    = cnt_q;

endmodule

// File: rtl/core_run_monitor.sv
// core_run_monitor: launcher and completion checker for the multicore array.
//   clock, reset      - clock, synchronous active-high reset
//   go                - run request pulse (ignored while a run is active)
//   start_addr_cfg    - per-core start PC, latched on go
//   end_pc_cfg        - per-core end PC, latched on go
//   PC, result_reg    - live fetch PC and x9 of each core
//   start             - one-cycle start pulse to the cores
//   program_address   - latched start PCs
//   busy              - run in progress
//   done/pass/timeout_mask, all_done - registered per-core verdicts
//   rd_sel, rd_cycles - combinational read of one core's frozen cycle count
module core_run_monitor
    import core_run_monitor_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_BITS   = 32,
    parameter int unsigned CYCLE_BITS     = 32,
    parameter int unsigned DRAIN_CYCLES   = 50,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              go,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0] start_addr_cfg,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0] end_pc_cfg,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0] PC,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]   result_reg,
    output logic                              start,
    output logic [NUM_CORES*ADDRESS_BITS-1:0] program_address,
    output logic                              busy,
    output logic [NUM_CORES-1:0]              done_mask,
    output logic [NUM_CORES-1:0]              pass_mask,
    output logic [NUM_CORES-1:0]              timeout_mask,
    output logic                              all_done,
    input  logic [SEL_W-1:0]                  rd_sel,
    output logic [CYCLE_BITS-1:0]             rd_cycles
);

    localparam int unsigned AW       = NUM_CORES * ADDRESS_BITS;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

    run_state_e            state_q, state_d;
    logic [AW-1:0]         prog_addr_q, prog_addr_d;
    logic [AW-1:0]         end_pc_q, end_pc_d;
    logic [31:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  all_done_q, all_done_d;
    logic                  launch, in_run, tmo_hit;
    logic [NUM_CORES-1:0]  done_vec, pass_vec, tmo_vec;
    logic [CYCLE_BITS-1:0] cycles [NUM_CORES];

    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        end_pc_d    = end_pc_q;
        tmo_cnt_d   = tmo_cnt_q;
        launch      = 1'b0;
        in_run      = (state_q == ST_RUN);
        // tmo_cnt_q holds completed RUN cycles, so this fires in RUN cycle TIMEOUT_CYCLES.
        tmo_hit     = TMO_EN && in_run && (tmo_cnt_q == TMO_LAST);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    launch      = 1'b1;
                    state_d     = ST_LAUNCH;
                    prog_addr_d = start_addr_cfg;
                    end_pc_d    = end_pc_cfg;
                    tmo_cnt_d   = '0;
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (!(&tmo_cnt_q)) tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (all_done_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Cleared on relaunch so the previous run's all_done cannot leak into LAUNCH.
        all_done_d = launch ? 1'b0 : (&done_vec);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prog_addr_q <= '0;
            end_pc_q    <= '0;
            tmo_cnt_q   <= '0;
            all_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            end_pc_q    <= end_pc_d;
            tmo_cnt_q   <= tmo_cnt_d;
            all_done_q  <= all_done_d;
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core_run_tracker #(
            .DATA_WIDTH   (DATA_WIDTH),
            .ADDRESS_BITS (ADDRESS_BITS),
            .CYCLE_BITS   (CYCLE_BITS),
            .DRAIN_CYCLES (DRAIN_CYCLES)
        ) u_trk (
            .clock       (clock),
            .reset       (reset),
            .clear       (launch),
            .run         (in_run),
            .timeout_hit (tmo_hit),
            .pc          (PC[i*ADDRESS_BITS +: ADDRESS_BITS]),
            .end_pc      (end_pc_q[i*ADDRESS_BITS +: ADDRESS_BITS]),
            .result      (result_reg[i*DATA_WIDTH +: DATA_WIDTH]),
            .done        (done_vec[i]),
            .pass        (pass_vec[i]),
            .timed_out   (tmo_vec[i]),
            .cycles      (cycles[i])
        );
    end

    always_comb begin
        rd_cycles = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (rd_sel == SEL_W'(i)) rd_cycles = cycles[i];
        end
    end

    assign start           = (state_q == ST_LAUNCH);
    assign busy            = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
    assign program_address = prog_addr_q;
    assign done_mask       = done_vec;
    assign pass_mask       = pass_vec;
    assign timeout_mask    = tmo_vec;
    assign all_done        = all_done_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// tb_core_run_monitor: directed bench for core_run_monitor with a behavioural
// model computing every core's verdict time, pass flag and cycle count from
// its end-PC hit cycle, the drain delay and the global run limit.
module tb_core_run_monitor;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int D  = 50;
    localparam int T  = 200;

    logic            clock = 1'b0;
    logic            reset, go;
    logic [N*AW-1:0] start_addr_cfg, end_pc_cfg, PC;
    logic [N*DW-1:0] result_reg;
    logic            start, busy, all_done;
    logic [N*AW-1:0] program_address;
    logic [N-1:0]    done_mask, pass_mask, timeout_mask;
    logic [1:0]      rd_sel;
    logic [CW-1:0]   rd_cycles;

    always #5 clock = ~clock;

    core_run_monitor #(
        .NUM_CORES      (N),
        .DATA_WIDTH     (DW),
        .ADDRESS_BITS   (AW),
        .CYCLE_BITS     (CW),
        .DRAIN_CYCLES   (D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .go              (go),
        .start_addr_cfg  (start_addr_cfg),
        .end_pc_cfg      (end_pc_cfg),
        .PC              (PC),
        .result_reg      (result_reg),
        .start           (start),
        .program_address (program_address),
        .busy            (busy),
        .done_mask       (done_mask),
        .pass_mask       (pass_mask),
        .timeout_mask    (timeout_mask),
        .all_done        (all_done),
        .rd_sel          (rd_sel),
        .rd_cycles       (rd_cycles)
    );

    int tests = 0;
    int fails = 0;
    int mode  = 0;   // 0: no check, 1: expect all-zero idle, 2: model run
    int t     = 0;   // cycles since the go cycle (1 = LAUNCH, RUN cycle r = t-1)

    int          hit       [N];  // RUN cycle of end-PC hit, 0 = never
    int          bad_after [N];  // x9 = bad_val once RUN cycle > bad_after
    logic [31:0] bad_val   [N];
    logic [31:0] st_addr   [N];
    logic [31:0] en_addr   [N];
    logic [31:0] ends      [N];

    // ---------------- model ----------------
    function automatic bit normal(input int i);
        return hit[i] > 0 && hit[i] + 1 + D < T;
    endfunction

    // RUN cycle at whose end the verdict is recorded.
    function automatic int dv(input int i);
        return normal(i) ? hit[i] + 1 + D : T;
    endfunction

    function automatic int cnt_exp(input int i);
        return (hit[i] > 0 && hit[i] <= T) ? hit[i] : T;
    endfunction

    function automatic logic [31:0] x9(input int i, input int r);
        return (r > bad_after[i]) ? bad_val[i] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    always @(negedge clock) begin : cmp
        int r, mx;
        logic [N-1:0] ed, ep, et;
        logic [127:0] pa;
        if (mode == 1) begin
            chk("idle_start", start, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done_mask, 0);
            chk("idle_pass", pass_mask, 0);
            chk("idle_timeout", timeout_mask, 0);
            chk("idle_all_done", all_done, 0);
            chk("idle_prog_addr", program_address, 0);
        end else if (mode == 2 && t >= 1) begin
            r  = t - 1;
            mx = 0;
            pa = '0;
            for (int i = 0; i < N; i++) begin
                ed[i] = (r > dv(i));
                et[i] = ed[i] && !normal(i);
                ep[i] = ed[i] && normal(i) && (x9(i, dv(i)) == 32'h0);
                if (dv(i) > mx) mx = dv(i);
                pa[i*AW +: AW] = st_addr[i];
            end
            chk("start", start, (t == 1));
            chk("busy", busy, (t == 1) || (r >= 1 && r <= mx + 2));
            chk("done_mask", done_mask, ed);
            chk("pass_mask", pass_mask, ep);
            chk("timeout_mask", timeout_mask, et);
            chk("all_done", all_done, (r >= mx + 2));
            chk("program_address", program_address, pa);
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_inputs();
        int r;
        r = t - 1;
        for (int i = 0; i < N; i++) begin
            // End PC also shows up during go/LAUNCH and long after the hit; both must be ignored.
            if (t <= 1 || r == hit[i] || (hit[i] > 0 && r == hit[i] + 80))
                PC[i*AW +: AW] = en_addr[i];
            else
                PC[i*AW +: AW] = en_addr[i] + 32'd4;
            result_reg[i*DW +: DW] = x9(i, r);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        t++;
        apply_inputs();
    endtask

    task automatic run_to(input int rr);
        while (t - 1 < rr) step();
    endtask

    task automatic launch(input int h0, input int h1, input int h2, input int h3,
                          input int bad_core, input int bad_from, input logic [31:0] bval);
        hit[0] = h0; hit[1] = h1; hit[2] = h2; hit[3] = h3;
        for (int i = 0; i < N; i++) begin
            st_addr[i]   = 32'(i * 16);
            en_addr[i]   = ends[i];
            bad_after[i] = 1 << 30;
            bad_val[i]   = 32'h0;
            start_addr_cfg[i*AW +: AW] = st_addr[i];
            end_pc_cfg[i*AW +: AW]     = en_addr[i];
        end
        if (bad_core >= 0) begin
            bad_after[bad_core] = bad_from;
            bad_val[bad_core]   = bval;
        end
        t    = 0;
        mode = 2;
        go   = 1'b1;
        apply_inputs();
        step();
        go = 1'b0;
        // Config changes after go must not reach the run.
        start_addr_cfg = ~start_addr_cfg;
        end_pc_cfg     = ~end_pc_cfg;
    endtask

    task automatic rd_check(input int i, input int lit);
        step();
        rd_sel = 2'(i);
        #1;
        chk($sformatf("rd_cycles_model[%0d]", i), rd_cycles, cnt_exp(i));
        chk($sformatf("rd_cycles_lit[%0d]", i), rd_cycles, lit);
    endtask

    task automatic do_reset();
        mode  = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        mode  = 1;
        repeat (5) step();
    endtask

    initial begin
        ends[0] = 32'hd0; ends[1] = 32'h188; ends[2] = 32'h240; ends[3] = 32'h2f8;
        for (int i = 0; i < N; i++) begin
            hit[i] = 0; bad_after[i] = 1 << 30; bad_val[i] = 32'h0;
            st_addr[i] = 32'h0; en_addr[i] = ends[i];
        end
        reset = 1'b1; go = 1'b0; rd_sel = 2'd0;
        start_addr_cfg = '0; end_pc_cfg = '0; PC = '0; result_reg = '0;

        // 1: idle after reset, no go
        step(); step();
        reset = 1'b0;
        mode  = 1;
        repeat (100) step();

        // 2: all pass
        launch(40, 70, 90, 120, -1, 0, 32'h0);
        run_to(180);
        chk("t2_pass_lit", pass_mask, 4'hF);
        chk("t2_all_done_lit", all_done, 1);
        rd_check(0, 40); rd_check(1, 70); rd_check(2, 90); rd_check(3, 120);

        // 3: core 2 x9 goes bad after the hit, relaunched from DONE
        launch(40, 70, 90, 120, 2, 90, 32'h5);
        run_to(180);
        chk("t3_pass_lit", pass_mask, 4'hB);
        chk("t3_done_lit", done_mask, 4'hF);

        // 4: cores 0 and 3 hit together
        launch(50, 70, 90, 50, -1, 0, 32'h0);
        run_to(101);
        chk("t4_done_before", done_mask, 4'h0);
        step();
        chk("t4_done_together", done_mask, 4'h9);
        run_to(180);
        rd_check(0, 50); rd_check(3, 50);

        // 5: core 1 never hits -> timeout
        launch(10, 0, 30, 60, -1, 0, 32'h0);
        run_to(210);
        chk("t5_timeout_lit", timeout_mask, 4'h2);
        chk("t5_pass_lit", pass_mask, 4'hD);
        chk("t5_done_lit", done_mask, 4'hF);
        chk("t5_all_done_lit", all_done, 1);
        rd_check(1, 200); rd_check(0, 10);

        // 6: reset in RUN, reset in DRAIN, go ignored during RUN
        launch(40, 70, 90, 120, -1, 0, 32'h0);
        run_to(20);
        do_reset();
        launch(10, 70, 90, 120, -1, 0, 32'h0);
        run_to(30);
        do_reset();
        launch(40, 70, 90, 120, -1, 0, 32'h0);
        run_to(5);
        go = 1'b1;
        step();
        go = 1'b0;
        run_to(180);
        chk("t6_pass_lit", pass_mask, 4'hF);
        rd_check(0, 40); rd_check(3, 120);

        mode = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
